fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end that sits between the PC/instruction memory and the IF/ID register of the pipelined CPU. It owns the fetch PC and issues one-outstanding requests to a variable-latency instruction memory. Returned words go into a DEPTH-entry FIFO tagged with PC+PC_STEP. Branch redirects flush the FIFO and discard any in-flight response, and a halt opcode stops fetching, which generalises the single-register PC/halt logic of the current design.

## Interface
- DATA_W, 16, instruction width; halt opcode is bits [DATA_W-1:DATA_W-4] == all ones
- ADDR_W, 16, PC/address width
- DEPTH, 4, FIFO entries, power of two, ≥2
- PC_STEP, 2, PC increment per instruction
- RESET_PC, 0, fetch PC after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request; accepted in every cycle it is high
- imem_addr  out  ADDR_W  request address (current fetch PC)
- imem_rvalid  in  1  response valid; ≥1 cycle after the accepted request
- imem_rdata  in  DATA_W  response word, qualified by imem_rvalid
- redirect  in  1  branch taken; flush and refetch
- redirect_pc  in  ADDR_W  new fetch PC
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_instr  out  DATA_W  head instruction
- out_pc  out  ADDR_W  head instruction address + PC_STEP
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- halted  out  1  halt word enqueued; fetching stopped

## Operation
- States: FETCH (no request outstanding), WAIT (one outstanding), DRAIN (outstanding response to be discarded), HALT.
- Issue condition: state FETCH, or WAIT with imem_rvalid and a non-halt word returning. Space must also be available: count < DEPTH, or count < DEPTH-1 when a response is enqueued the same cycle.
  - A pop in the same cycle is not credited.
  - imem_req is combinational from imem_rvalid.
- On issue: imem_addr = fetch PC; fetch PC += PC_STEP (mod 2^ADDR_W, wraps); the request's address is latched; next state WAIT.
- WAIT and imem_rvalid: enqueue {imem_rdata, latched addr + PC_STEP}.
  - If the word is a halt: next state HALT, halted=1, no request issued.
  - Else: next state WAIT if a request issued, otherwise FETCH.
- Pop: out_valid && out_ready removes head. Push and pop in the same cycle are both allowed, including at full: count is unchanged.
- Redirect has top priority over all other events in all states. In the redirect cycle:
  - imem_req is forced 0.
  - Next cycle: FIFO empty (count 0, out_valid 0), fetch PC = redirect_pc, halted = 0.
  - If in WAIT without imem_rvalid that cycle, next state is DRAIN. Otherwise (including a response arriving in the same cycle, which is dropped), next state is FETCH.
- DRAIN: imem_req=0; the next imem_rvalid is discarded, then FETCH. A second redirect in DRAIN updates the fetch PC and stays in DRAIN.
- HALT: no requests; the FIFO still drains normally; leaves only via redirect (to FETCH) or reset.
- A pop in the redirect cycle still completes if out_valid was 1.

## Timing
- Reset values: fetch PC=RESET_PC, state FETCH, count=0, out_valid=0, out_instr=0, out_pc=0, halted=0. In the reset cycle, imem_req=0 and imem_addr=RESET_PC. The first request goes out in the first cycle with rst_n=1.
- Reset asserted mid-operation discards the FIFO and any outstanding response. A response arriving in the reset cycle is dropped.
- Without bypass: enqueued entry visible on out_valid the cycle after imem_rvalid. With 1-cycle memory latency, sustained throughput is 1 instruction/cycle.
- Redirect to first new request: 1 cycle (FETCH) or after the discarded response (DRAIN).
- halted rises the cycle after the halt word's imem_rvalid.

## Configuration
- FETCHQ_BYPASS_EN defined: when the FIFO is empty, imem_rvalid with a non-discarded word drives out_valid/out_instr/out_pc combinationally in the same cycle.
  - If out_ready is also 1 that cycle, the word is not stored and count stays 0.
  - Halt detection is unchanged.
- Undefined: every word is registered first; 1-cycle minimum FIFO latency.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory, out_ready=1 -> imem_addr 0,2,4,… on consecutive cycles; out_pc 2,4,6,…; count ≤1.
- out_ready=0, DEPTH=4 -> exactly 4 requests issued (0,2,4,6); count=4; imem_req=0. Then one pop -> one new request at 8.
- 3-cycle memory latency, redirect to 0x0100 one cycle after request at 0x0004 -> stale response dropped; FIFO empty; next imem_addr=0x0100; first out_pc=0x0102.
- Redirect in the same cycle as imem_rvalid -> word never appears on out; FETCH next cycle at redirect_pc.
- Memory returns 0xF000 at address 6 -> halted=1 next cycle; no further imem_req; 0xF000 delivered with out_pc=8. Then redirect to 0 -> halted=0, fetching resumes.
- Empty FIFO, out_ready=1: with FETCHQ_BYPASS_EN, word visible the same cycle as imem_rvalid and count stays 0. Without it, word visible 1 cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one request outstanding, and buffers
// returned words in a DEPTH-entry FIFO. Define FETCHQ_BYPASS_EN for a same-cycle empty-FIFO bypass.
module fetch_queue #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_rvalid,
  input  logic [DATA_W-1:0]          imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0]   Full   = CntW'(DEPTH);
  localparam logic [CntW-1:0]   FullM1 = CntW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] Step   = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RstPc  = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {StFetch, StWait, StDrain, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic rsp_wait, rsp_halt, push, store, pop, empty, space, issue, byp;

  always_comb begin
    rsp_wait = (state_q == StWait) && imem_rvalid;
    rsp_halt = &imem_rdata[DATA_W-1:DATA_W-4];
    push     = rsp_wait && !redirect;
    empty    = (cnt_q == '0);
`ifdef FETCHQ_BYPASS_EN
    byp      = empty && push && rst_n;
`else
    byp      = 1'b0;
`endif
    // A bypassed word consumed in the same cycle never occupies a slot.
    store    = push && !(byp && out_ready);
    pop      = out_ready && !empty;
    // A pop in this cycle is deliberately not credited to the space check.
    space    = push ? (cnt_q < FullM1) : (cnt_q < Full);
    issue    = rst_n && !redirect && space &&
               ((state_q == StFetch) || (rsp_wait && !rsp_halt));
  end

  assign imem_req  = issue;
  assign imem_addr = rst_n ? pc_q : RstPc;
  assign count     = cnt_q;
  assign halted    = halted_q;

  always_comb begin
    out_valid = !empty || byp;
    out_instr = '0;
    out_pc    = '0;
    if (!empty) begin
      out_instr = instr_mem[rptr_q];
      out_pc    = pc_mem[rptr_q];
    end else if (byp) begin
      out_instr = imem_rdata;
      out_pc    = addr_q + Step;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      cnt_d    = '0;
      wptr_d   = '0;
      rptr_d   = '0;
      halted_d = 1'b0;
      // An outstanding response not yet returned must be swallowed before refetching.
      if (((state_q == StWait) || (state_q == StDrain)) && !imem_rvalid) begin
        state_d = StDrain;
      end else begin
        state_d = StFetch;
      end
    end else begin
      if (issue) begin
        pc_d   = pc_q + Step;
        addr_d = pc_q;
      end
      if (store) wptr_d = wptr_q + PtrW'(1);
      if (pop)   rptr_d = rptr_q + PtrW'(1);
      if (store && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (!store && pop) cnt_d = cnt_q - CntW'(1);
      unique case (state_q)
        StFetch: if (issue) state_d = StWait;
        StWait: begin
          if (imem_rvalid) begin
            if (rsp_halt) begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end else begin
              state_d = issue ? StWait : StFetch;
            end
          end
        end
        StDrain: if (imem_rvalid) state_d = StFetch;
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= RstPc;
      addr_q   <= RstPc;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && store) begin
      instr_mem[wptr_q] <= imem_rdata;
      pc_mem[wptr_q]    <= addr_q + Step;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: the bench acts as instruction memory, models fetch order
// with a queue of expected words, and a negedge monitor checks every word the DUT delivers.
module tb_fetch_queue;

  localparam int unsigned DW       = 16;
  localparam int unsigned AW       = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned STEP     = 2;
  localparam int unsigned RESET_PC = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;
  logic          halted;

  fetch_queue #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PC_STEP(STEP), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: memory-side view of the fetch stream.
  logic [AW-1:0] m_pc      = AW'(RESET_PC);
  logic [AW-1:0] pend_addr = '0;
  bit            pending   = 0;
  bit            discard   = 0;
  bit            halted_m  = 0;
  bit            started   = 0;
  int            lat_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {1'b0, a[14:0]} ^ 16'h2A5C;
  endfunction

  // Monitor: every accepted output word must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("pop_unexpected", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_instr", 32'(out_instr), 32'(e.instr));
        chk("out_pc", 32'(out_pc), 32'(e.pc));
      end
    end
    if (!rst_n || redirect) sbq.delete();
  end

  task automatic run_phase(input int cycles, input int max_lat, input int ready_pct,
                           input int redir_pct, input int halt_pct, input int rst_at);
    for (int cyc = 0; cyc < cycles; cyc++) begin
      logic [DW-1:0] word;
      bit hw, enq, req_exp, bypx;
      int occ;
      @(posedge clk);
      #1;
      if (started) begin
        chk("count", 32'(count), 32'(sbq.size()));
        chk("halted", 32'(halted), 32'(halted_m));
      end
      rst_n       = (cyc != rst_at);
      redirect    = ($urandom_range(99) < redir_pct);
      redirect_pc = ($urandom_range(3) == 0) ? 16'hFFF8 : (AW'($urandom) & 16'hFFFE);
      out_ready   = ($urandom_range(99) < ready_pct);
      imem_rvalid = 1'b0;
      imem_rdata  = DW'($urandom);
      word        = '0;
      if (pending) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          word = mem_word(pend_addr);
          if ($urandom_range(99) < halt_pct) word = 16'hF000 | {4'h0, pend_addr[11:0]};
          imem_rvalid = 1'b1;
          imem_rdata  = word;
        end
      end
      #1;
      occ     = sbq.size();
      hw      = imem_rvalid && (&word[DW-1:DW-4]);
      enq     = imem_rvalid && !discard && !redirect && rst_n;
      req_exp = rst_n && !redirect && !halted_m && !discard &&
                (!pending || (imem_rvalid && !hw)) && ((occ + int'(enq)) < int'(DEPTH));
`ifdef FETCHQ_BYPASS_EN
      bypx = (occ == 0) && enq;
`else
      bypx = 0;
`endif
      chk("imem_req", 32'(imem_req), 32'(req_exp));
      if (!rst_n) chk("imem_addr_rst", 32'(imem_addr), 32'(RESET_PC));
      else if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      if (started) begin
        chk("out_valid", 32'(out_valid), 32'((occ != 0) || bypx));
        if (!out_valid) chk("out_idle_zero", {out_instr, out_pc}, 32'd0);
      end
      if (enq) sbq.push_back('{instr: word, pc: pend_addr + AW'(STEP)});
      if (!rst_n) begin
        pending  = 0;
        discard  = 0;
        halted_m = 0;
        m_pc     = AW'(RESET_PC);
        started  = 1;
      end else begin
        if (imem_rvalid) begin
          pending = 0;
          discard = 0;
          if (enq && hw) halted_m = 1;
        end
        if (redirect) begin
          halted_m = 0;
          m_pc     = redirect_pc;
          if (pending) discard = 1;
        end
        if (imem_req) begin
          pending   = 1;
          pend_addr = imem_addr;
          lat_cnt   = $urandom_range(max_lat, 1);
          m_pc      = m_pc + AW'(STEP);
        end
      end
    end
  endtask

  initial begin
    run_phase(1,   1, 100,  0, 0,   0);
    run_phase(60,  1, 100,  0, 0,  -1);
    run_phase(30,  1,   0,  0, 0,  -1);
    run_phase(40,  2,  50,  0, 0,  -1);
    run_phase(400, 3,  60,  6, 3,  -1);
    run_phase(200, 1,  80,  4, 2, 100);
    run_phase(400, 4,  40,  8, 4,  -1);
    run_phase(60,  1, 100, 30, 0,  -1);
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
